// File: rtl/regfile_pkg.sv
// Shared types and helpers for the integer register file and its pending scoreboard.
package regfile_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_SWEEP = 1'b1
    } rf_state_t;

    // Address width for a given register count (at least one bit).
    function automatic int unsigned rf_aw(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: reserve sets, write clears, sweep clears one location per cycle.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int unsigned DEPTH = 32,
    localparam int unsigned AW    = rf_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en,
    input  logic [AW-1:0]    set_loc,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_loc,
    input  logic             sweep_en,
    input  logic [AW-1:0]    sweep_loc,
    output logic [DEPTH-1:0] pending
);

    logic [DEPTH-1:0] r_pending;

    // A same-cycle reserve beats the write: the new producer owns the register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (sweep_en && sweep_loc == AW'(i)) begin
                    r_pending[i] <= 1'b0;
                end else if (set_en && set_loc == AW'(i)) begin
                    r_pending[i] <= 1'b1;
                end else if (clr_en && clr_loc == AW'(i)) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    assign pending = r_pending;

endmodule

// File: rtl/register_file.sv
// Multi-port integer register file with zero register, write bypass, pending
// scoreboard and a one-register-per-cycle sweep clear.
module register_file
    import regfile_pkg::*;
#(
    parameter  int unsigned WIDTH    = 32,
    parameter  int unsigned DEPTH    = 32,
    parameter  int unsigned NREAD    = 2,
    parameter  bit          ZERO_REG = 1'b1,
    localparam int unsigned AW       = rf_aw(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   write_enabled,
    input  logic [AW-1:0]          write_location,
    input  logic [WIDTH-1:0]       write_data,
    input  logic                   reserve_enabled,
    input  logic [AW-1:0]          reserve_location,
    input  logic                   clear,
    output logic                   busy,
    input  logic [NREAD*AW-1:0]    read_location,
    output logic [NREAD*WIDTH-1:0] read_data,
    output logic [NREAD-1:0]       read_ready
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    rf_state_t        r_state;
    logic [AW-1:0]    r_index;
    logic             r_busy;
    logic [DEPTH-1:0] w_pending;
    logic             w_wr_ok;
    logic             w_rsv_ok;

    function automatic logic f_in_range(input logic [AW-1:0] loc);
        return 32'(loc) < 32'(DEPTH);
    endfunction

    function automatic logic f_is_zero(input logic [AW-1:0] loc);
        return ZERO_REG && (loc == '0);
    endfunction

    assign w_wr_ok  = reset && write_enabled && !r_busy &&
                      f_in_range(write_location) && !f_is_zero(write_location);
    assign w_rsv_ok = reset && reserve_enabled && !r_busy &&
                      f_in_range(reserve_location) && !f_is_zero(reserve_location);

    regfile_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_en    (w_rsv_ok),
        .set_loc   (reserve_location),
        .clr_en    (w_wr_ok),
        .clr_loc   (write_location),
        .sweep_en  (r_busy),
        .sweep_loc (r_index),
        .pending   (w_pending)
    );

    // Storage and sweep FSM; busy is registered alongside the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= RF_IDLE;
            r_index <= '0;
            r_busy  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                RF_IDLE: begin
                    if (w_wr_ok) begin
                        r_mem[write_location] <= write_data;
                    end
                    if (clear) begin
                        r_state <= RF_SWEEP;
                        r_index <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                RF_SWEEP: begin
                    r_mem[r_index] <= '0;
                    if (r_index == AW'(DEPTH - 1)) begin
                        r_state <= RF_IDLE;
                        r_index <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_index <= r_index + AW'(1);
                    end
                end
                default: begin
                    r_state <= RF_IDLE;
                    r_index <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;

    for (genvar p = 0; p < NREAD; p++) begin : g_read
        logic [AW-1:0]    w_loc;
        logic [WIDTH-1:0] w_data;
        logic             w_ready;

        assign w_loc = read_location[p*AW +: AW];

        // Sweep hides readiness and bypass; out-of-range reads return 0, not ready.
        always_comb begin
            w_data  = '0;
            w_ready = 1'b0;
            if (f_in_range(w_loc)) begin
                if (r_busy) begin
                    w_data = r_mem[w_loc];
                end else if (f_is_zero(w_loc)) begin
                    w_ready = 1'b1;
                end else if (w_wr_ok && write_location == w_loc) begin
                    w_data  = write_data;
                    w_ready = 1'b1;
                end else begin
                    w_data  = r_mem[w_loc];
                    w_ready = !w_pending[w_loc];
                end
            end
        end

        assign read_data[p*WIDTH +: WIDTH] = w_data;
        assign read_ready[p]               = w_ready;
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: default 32x32 two-port instance against a
// behavioural model, plus a small 8-entry four-port instance without a zero register.
module tb_register_file;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH 32, DEPTH 32, NREAD 2, ZERO_REG 1
    logic        reset, we, re, clr, busy;
    logic [4:0]  wl, rl;
    logic [31:0] wd;
    logic [9:0]  rloc;
    logic [63:0] rdata;
    logic [1:0]  rready;

    register_file u_dut (
        .clk              (clk),
        .reset            (reset),
        .write_enabled    (we),
        .write_location   (wl),
        .write_data       (wd),
        .reserve_enabled  (re),
        .reserve_location (rl),
        .clear            (clr),
        .busy             (busy),
        .read_location    (rloc),
        .read_data        (rdata),
        .read_ready       (rready)
    );

    // Instance B: DEPTH 8, NREAD 4, ZERO_REG 0
    logic         b_reset, b_we, b_re, b_clr, b_busy;
    logic [2:0]   b_wl, b_rl;
    logic [31:0]  b_wd;
    logic [11:0]  b_rloc;
    logic [127:0] b_rdata;
    logic [3:0]   b_rready;

    register_file #(
        .WIDTH    (32),
        .DEPTH    (8),
        .NREAD    (4),
        .ZERO_REG (1'b0)
    ) u_dut_b (
        .clk              (clk),
        .reset            (b_reset),
        .write_enabled    (b_we),
        .write_location   (b_wl),
        .write_data       (b_wd),
        .reserve_enabled  (b_re),
        .reserve_location (b_rl),
        .clear            (b_clr),
        .busy             (b_busy),
        .read_location    (b_rloc),
        .read_data        (b_rdata),
        .read_ready       (b_rready)
    );

    typedef struct {
        int          dut;
        int          port;   // -1 selects the busy output
        logic [31:0] data;
        logic        ready;
        logic        busy;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: outputs are settled mid-cycle; compare everything queued for this cycle.
    exp_t me;
    always @(negedge clk) begin
        while (q.size() > 0) begin
            me = q.pop_front();
            if (me.dut == 0) begin
                if (me.port < 0) begin
                    check({me.name, " busy"}, 32'(busy), 32'(me.busy));
                end else begin
                    check({me.name, " data"}, rdata[me.port*32 +: 32], me.data);
                    check({me.name, " ready"}, 32'(rready[me.port]), 32'(me.ready));
                end
            end else begin
                if (me.port < 0) begin
                    check({me.name, " busy"}, 32'(b_busy), 32'(me.busy));
                end else begin
                    check({me.name, " data"}, b_rdata[me.port*32 +: 32], me.data);
                    check({me.name, " ready"}, 32'(b_rready[me.port]), 32'(me.ready));
                end
            end
        end
    end

    // Reference model for instance A
    logic [31:0] m_mem [32];
    bit          m_pend [32];
    bit          m_sweep;
    int          m_pos;

    function automatic bit wr_accept();
        return reset && we && !m_sweep && (wl != 5'd0);
    endfunction

    function automatic bit rsv_accept();
        return reset && re && !m_sweep && (rl != 5'd0);
    endfunction

    task automatic push_a(input string tag);
        logic [4:0]  loc;
        logic [31:0] d;
        logic        r;
        for (int p = 0; p < 2; p++) begin
            loc = rloc[p*5 +: 5];
            if (m_sweep) begin
                d = m_mem[loc];
                r = 1'b0;
            end else if (loc == 5'd0) begin
                d = 32'd0;
                r = 1'b1;
            end else if (wr_accept() && wl == loc) begin
                d = wd;
                r = 1'b1;
            end else begin
                d = m_mem[loc];
                r = !m_pend[loc];
            end
            q.push_back('{0, p, d, r, 1'b0, $sformatf("%s p%0d r%0d", tag, p, loc)});
        end
        q.push_back('{0, -1, 32'd0, 1'b0, m_sweep, tag});
    endtask

    task automatic model_a_update();
        bit w_ok, r_ok;
        w_ok = wr_accept();
        r_ok = rsv_accept();
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  = 32'd0;
                m_pend[i] = 1'b0;
            end
            m_sweep = 1'b0;
            m_pos   = 0;
        end else if (m_sweep) begin
            m_mem[m_pos]  = 32'd0;
            m_pend[m_pos] = 1'b0;
            m_pos++;
            if (m_pos == 32) m_sweep = 1'b0;
        end else begin
            if (w_ok) begin
                m_mem[wl]  = wd;
                m_pend[wl] = 1'b0;
            end
            if (r_ok) m_pend[rl] = 1'b1;
            if (clr) begin
                m_sweep = 1'b1;
                m_pos   = 0;
            end
        end
    endtask

    task automatic tick_a(input string tag);
        push_a(tag);
        @(posedge clk);
        model_a_update();
        #1;
        we = 1'b0; re = 1'b0; clr = 1'b0; reset = 1'b1;
    endtask

    task automatic count_sweep(input string tag);
        int n;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (busy) n++;
            if (c == 3) begin
                we = 1'b1; wl = 5'd9; wd = 32'h0000_0ABC;
                rloc = {5'd1, 5'd9};
            end
            tick_a(tag);
        end
        check({tag, " busy_cycles"}, 32'(n), 32'd32);
    endtask

    task automatic read_all_a(input string tag);
        for (int i = 0; i < 32; i += 2) begin
            rloc = {5'(i + 1), 5'(i)};
            tick_a(tag);
        end
    endtask

    task automatic push_b(input string tag, input logic [31:0] d, input logic r);
        for (int p = 0; p < 4; p++) begin
            q.push_back('{1, p, d, r, 1'b0, $sformatf("%s p%0d", tag, p)});
        end
        q.push_back('{1, -1, 32'd0, 1'b0, 1'b0, tag});
    endtask

    task automatic tick_b();
        @(posedge clk);
        #1;
        b_we = 1'b0; b_re = 1'b0; b_clr = 1'b0; b_reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; we = 1'b0; re = 1'b0; clr = 1'b0;
        wl = '0; rl = '0; wd = '0; rloc = '0;
        b_reset = 1'b0; b_we = 1'b0; b_re = 1'b0; b_clr = 1'b0;
        b_wl = '0; b_rl = '0; b_wd = '0; b_rloc = '0;
        m_sweep = 1'b0; m_pos = 0;

        @(posedge clk);
        model_a_update();
        #1;
        reset = 1'b1;
        b_reset = 1'b1;

        rloc = {5'd0, 5'd3};
        tick_a("post_reset");

        we = 1'b1; wl = 5'd5; wd = 32'hDEAD_BEEF; rloc = {5'd0, 5'd5};
        tick_a("bypass_r5");
        tick_a("stored_r5");

        we = 1'b1; wl = 5'd0; wd = 32'h0000_1234; rloc = {5'd0, 5'd5};
        tick_a("write_r0");
        tick_a("r0_after");

        re = 1'b1; rl = 5'd7; rloc = {5'd5, 5'd7};
        tick_a("reserve_r7");
        tick_a("r7_pending");
        we = 1'b1; wl = 5'd7; wd = 32'h55;
        tick_a("r7_bypass");
        tick_a("r7_after");
        we = 1'b1; wl = 5'd7; wd = 32'h66; re = 1'b1; rl = 5'd7;
        tick_a("r7_wr_rsv");
        tick_a("r7_pending2");

        for (int i = 1; i < 32; i++) begin
            we = 1'b1; wl = 5'(i); wd = $urandom | 32'h1; rloc = {5'(i), 5'(i - 1)};
            tick_a("fill");
        end

        clr = 1'b1;
        tick_a("clear");
        count_sweep("sweep1");
        read_all_a("swept");

        clr = 1'b1;
        tick_a("clear2");
        for (int c = 0; c < 9; c++) tick_a("sweep2");
        reset = 1'b0;
        tick_a("rst_mid");
        read_all_a("after_rst");
        clr = 1'b1;
        tick_a("clear3");
        count_sweep("sweep3");

        for (int c = 0; c < 400; c++) begin
            we    = 1'($urandom);
            wl    = 5'($urandom);
            wd    = $urandom;
            re    = ($urandom % 3) == 0;
            rl    = 5'($urandom);
            clr   = ($urandom % 64) == 0;
            reset = ($urandom % 128) != 0;
            rloc  = 10'($urandom);
            if (($urandom % 4) == 0) rloc[4:0] = wl;
            tick_a("random");
        end

        // Instance B: four ports, location 0 is an ordinary register.
        push_b("b_reset", 32'd0, 1'b1);
        tick_b();
        b_we = 1'b1; b_wl = 3'd0; b_wd = 32'hA;
        push_b("b_bypass_r0", 32'hA, 1'b1);
        tick_b();
        push_b("b_r0", 32'hA, 1'b1);
        tick_b();
        b_re = 1'b1; b_rl = 3'd3; b_rloc = {4{3'd3}};
        push_b("b_rsv_same", 32'd0, 1'b1);
        tick_b();
        push_b("b_r3_pend", 32'd0, 1'b0);
        tick_b();
        b_we = 1'b1; b_wl = 3'd7; b_wd = 32'h77; b_rloc = {4{3'd7}};
        push_b("b_bypass_r7", 32'h77, 1'b1);
        tick_b();
        push_b("b_r7", 32'h77, 1'b1);
        tick_b();

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

Parametrised multi-port integer register file for the riscv32 core, successor to the fixed two-read-port data register block. It adds a configurable read-port count, a hardwired zero register, write-to-read bypass, a per-register pending scoreboard for long-latency producers, and a multi-cycle sweep clear with a busy indication. It sits between decode (reads, reserves) and writeback (writes).

## Interface
- WIDTH, 32, data word width in bits
- DEPTH, 32, number of registers (≥2); AW = $clog2(DEPTH)
- NREAD, 2, number of read ports (≥1)
- ZERO_REG, 1, when 1 location 0 reads as 0 and ignores writes/reserves
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-low reset
- write_enabled  input  1  write strobe
- write_location  input  AW  write address
- write_data  input  WIDTH  write data
- reserve_enabled  input  1  mark a register pending (producer issued)
- reserve_location  input  AW  register to mark pending
- clear  input  1  request a sweep clear of all registers
- busy  output  1  sweep clear in progress
- read_location  input  NREAD×AW  per-port read address
- read_data  output  NREAD×WIDTH  per-port read data
- read_ready  output  NREAD  per-port: value is final (not pending)

## Operation
- Storage: DEPTH×WIDTH registers plus DEPTH pending bits.
- Write: write_enabled=1, busy=0, location < DEPTH, and not (ZERO_REG and location 0) → register updated and its pending bit cleared at the posedge. Otherwise ignored.
- Reserve: reserve_enabled=1, busy=0, same address filters → pending bit set at the posedge.
- Write and reserve to the same location in the same cycle: data is stored, and the pending bit ends at 1 (the new producer wins).
- Reads are combinational per port:
  - ZERO_REG and address 0 → data 0, ready 1.
  - Address ≥ DEPTH → data 0, ready 0.
  - Bypass: an accepted write to the same address this cycle → data = write_data, ready = 1. A same-cycle reserve does not affect the read until the next cycle.
  - Otherwise → stored data, ready = ~pending.
  - While busy=1 → data = stored contents, ready = 0, and no bypass.
- FSM (states in the package):
  - IDLE: clear=1 moves to SWEEP and sets index to 0. A write or reserve presented in that same cycle is still accepted.
  - SWEEP: each cycle, register[index] ← 0 and pending[index] ← 0, then index increments. When index = DEPTH−1, the state returns to IDLE after that clear.
  - clear asserted during SWEEP is ignored. write and reserve requests during SWEEP are dropped.
- Reset (reset=0 at a posedge): all registers are 0, all pending bits are 0, state is IDLE, index is 0. Reset overrides a sweep in progress and any concurrent write, reserve, or clear.
- Output values after reset: busy=0, all read_data=0, all read_ready=1 for in-range addresses.

## Timing
- Read latency 0 (combinational from read_location and from write-port inputs via the bypass).
- Write, reserve, and pending updates are visible on the read ports in the cycle after the posedge (bypass excepted).
- busy rises in the cycle after clear is sampled in IDLE and stays high for exactly DEPTH cycles.
- The first write after a sweep is accepted in the first cycle with busy=0.
- No combinational path from clear to busy. busy is a registered state decode.

## Structure
- Package regfile_pkg:
  - rf_state_t enum {RF_IDLE, RF_SWEEP}
  - localparam helper for AW
- Sub-module regfile_scoreboard (DEPTH pending bits with set, clear, and sweep-clear inputs) holds the reserve/write priority and is verified standalone.
- Top-level register_file holds the storage array, the FSM, and the NREAD generate loop of read muxes with bypass.

## Test plan
- Reset, then read ports 0/1 at addresses 3/0 → data 0/0, ready 1/1, busy 0.
- Write 0xDEADBEEF to r5 with read port 0 at r5 in the same cycle → port 0 shows 0xDEADBEEF immediately. The next cycle still shows 0xDEADBEEF. Write 0x1234 to r0 → r0 reads 0.
- Reserve r7 → the next cycle shows ready[r7]=0. Write 0x55 to r7 → bypass gives 0x55 with ready=1. Write and reserve r7 in the same cycle → the next cycle shows data 0x55-replacement value, ready=0.
- Fill r1..r31 with nonzero values, pulse clear → busy high exactly 32 cycles. A write to r9 during the sweep is dropped. After busy falls, every register reads 0 with ready=1.
- Start a sweep, assert reset=0 at sweep cycle 10 → busy is 0 the next cycle, all registers read 0, and a subsequent clear starts a fresh 32-cycle sweep.
- NREAD=4, DEPTH=8, ZERO_REG=0: write r0=0xA, then read all four ports at r0 → 0xA on every port. Address 9 is not representable; an address of 8 is not representable either (AW=3).
